// File: rtl/bcd_digit_sequencer_if.sv
// Request/result bundle between the display operand selector and the BCD sequencer.
// The master side issues conversion requests; the slave side returns registered digits.
interface bcd_digit_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic [WIDTH-1:0]    value_in;
    logic                start;
    logic                auto_en;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   blank_mask;
    logic                overflow;

    modport master (
        output value_in, start, auto_en,
        input  busy, done, digits_out, blank_mask, overflow
    );

    modport slave (
        input  value_in, start, auto_en,
        output busy, done, digits_out, blank_mask, overflow
    );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Sequential double-dabble binary-to-BCD converter with request scheduling.
// One shift-add-3 iteration per clock; results are only published once complete.
module bcd_digit_sequencer #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bcd_digit_sequencer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = 4*DIGITS + WIDTH;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t              state;
    state_t              state_next;
    logic [SW-1:0]       shreg;
    logic [SW-1:0]       adjusted;
    logic [SW-1:0]       shifted;
    logic [CW-1:0]       count;
    logic                sticky;
    logic                pending;
    logic [WIDTH-1:0]    last_value;
    logic [4*DIGITS-1:0] digits_q;
    logic [4*DIGITS-1:0] digits_final;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blank_final;
    logic                overflow_q;
    logic                done_q;
    logic                new_request;
    logic                accept;
    logic                finish;
    logic                shift_out;
    logic                zero_above;

    assign new_request = bus.start | (bus.auto_en & (bus.value_in != last_value));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (new_request || pending) begin
                    accept     = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (count == CW'(WIDTH-1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: correct each BCD nibble, then shift the whole register.
    always_comb begin
        adjusted = shreg;
        for (int i = 0; i < DIGITS; i++) begin
            if (shreg[WIDTH+4*i +: 4] >= 4'd5) begin
                adjusted[WIDTH+4*i +: 4] = shreg[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        shift_out    = adjusted[SW-1];
        shifted      = {adjusted[SW-2:0], 1'b0};
        digits_final = shifted[WIDTH +: 4*DIGITS];
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        blank_final = '0;
        zero_above  = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            zero_above     = zero_above & (digits_final[4*i +: 4] == 4'd0);
            blank_final[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            count      <= '0;
            sticky     <= 1'b0;
            pending    <= 1'b0;
            last_value <= '0;
            digits_q   <= '0;
            blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shreg      <= {{(4*DIGITS){1'b0}}, bus.value_in};
                last_value <= bus.value_in;
                count      <= '0;
                sticky     <= 1'b0;
                pending    <= 1'b0;
            end else if (state == CONVERT) begin
                shreg  <= shifted;
                sticky <= sticky | shift_out;
                count  <= count + CW'(1);
                if (new_request) begin
                    pending <= 1'b1;
                end
                if (finish) begin
                    digits_q   <= digits_final;
                    blank_q    <= blank_final;
                    overflow_q <= sticky | shift_out;
                    done_q     <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = (state == CONVERT);
    assign bus.done       = done_q;
    assign bus.digits_out = digits_q;
    assign bus.blank_mask = blank_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Randomised self-checking bench for bcd_digit_sequencer against a decimal arithmetic model.
module tb_bcd_digit_sequencer;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_digit_sequencer_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus();

    bcd_digit_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] model_digits(input logic [31:0] v);
        longint unsigned x = v;
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i and all above are zero exactly when the displayed remainder is below 10^i.
    function automatic logic [7:0] model_blank(input logic [31:0] v);
        longint unsigned m = longint'(v) % 100000000;
        longint unsigned p = 10;
        logic [7:0] b = '0;
        for (int i = 1; i < 8; i++) begin
            b[i] = (m < p);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic logic model_overflow(input logic [31:0] v);
        return longint'(v) >= 64'd100000000;
    endfunction

    task automatic test_reset();
        int dones = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.digits_out !== 32'h0 ||
            bus.blank_mask !== 8'hFE || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%b done=%b digits=%h blank=%h ovf=%b expected 0 0 00000000 fe 0",
                     bus.busy, bus.done, bus.digits_out, bus.blank_mask, bus.overflow);
        end
        bus.auto_en = 1'b1;
        bus.value_in = 32'd0;
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL reset_auto_zero got %0d done pulses expected 0", dones);
        end
        bus.auto_en = 1'b0;
    endtask

    task automatic test_normal();
        int cycles = 0;
        int busy_cycles = 0;
        bit seen = 0;
        bus.value_in = 32'd12345678;
        bus.start = 1'b1;
        while (cycles < 40 && !seen) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) bus.start = 1'b0;
            if (bus.done) seen = 1;
            else if (bus.busy) busy_cycles++;
        end
        checks++;
        if (!seen || cycles - 1 != WIDTH) begin
            errors++;
            $display("[TB] FAIL normal_latency got seen=%0d edges=%0d expected 1 %0d", seen, cycles - 1, WIDTH);
        end
        checks++;
        if (busy_cycles != WIDTH || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_busy got %0d busy cycles busy_at_done=%b expected %0d 0",
                     busy_cycles, bus.busy, WIDTH);
        end
        checks++;
        if (bus.digits_out !== 32'h12345678 || bus.blank_mask !== 8'h00 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_result got %h %h %b expected 12345678 00 0",
                     bus.digits_out, bus.blank_mask, bus.overflow);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_done_pulse got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_values(input string name, input logic [31:0] vals[$]);
        foreach (vals[k]) begin
            int cycles = 0;
            bit seen = 0;
            bus.value_in = vals[k];
            bus.start = 1'b1;
            while (cycles < 40 && !seen) begin
                @(negedge clk);
                cycles++;
                if (cycles == 1) bus.start = 1'b0;
                if (bus.done) seen = 1;
            end
            checks++;
            if (!seen || bus.digits_out !== model_digits(vals[k]) ||
                bus.blank_mask !== model_blank(vals[k]) || bus.overflow !== model_overflow(vals[k])) begin
                errors++;
                $display("[TB] FAIL %s v=%0d got done=%0d %h %h %b expected 1 %h %h %b", name, vals[k], seen,
                         bus.digits_out, bus.blank_mask, bus.overflow,
                         model_digits(vals[k]), model_blank(vals[k]), model_overflow(vals[k]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] vals[$] = '{32'd907, 32'd0, 32'd99999999, 32'd100000000, 32'hFFFFFFFF, 32'd9, 32'd10};
        test_values("boundary", vals);
    endtask

    task automatic test_random();
        logic [31:0] vals[$];
        for (int k = 0; k < 15; k++) begin
            case (k % 3)
                0: vals.push_back($urandom);
                1: vals.push_back($urandom_range(0, 99999999));
                default: vals.push_back($urandom_range(0, 999));
            endcase
        end
        test_values("random", vals);
    endtask

    task automatic test_back_to_back();
        logic [31:0] first = $urandom_range(100, 99999999);
        logic [31:0] got[2];
        int at[2];
        int dones = 0;
        bit busy34 = 0;
        bus.value_in = first;
        bus.start = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) bus.start = 1'b1;
            if (c == 6) begin
                bus.start = 1'b0;
                bus.value_in = 32'd42;
            end
            if (c == 34) busy34 = bus.busy;
            if (bus.done) begin
                if (dones < 2) begin
                    got[dones] = bus.digits_out;
                    at[dones] = c;
                end
                dones++;
            end
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d done pulses expected 2", dones);
        end else begin
            checks++;
            if (got[0] !== model_digits(first) || at[0] != WIDTH + 1) begin
                errors++;
                $display("[TB] FAIL b2b_first got %h at %0d expected %h at %0d", got[0], at[0],
                         model_digits(first), WIDTH + 1);
            end
            checks++;
            if (got[1] !== 32'h00000042 || at[1] != 2*WIDTH + 2) begin
                errors++;
                $display("[TB] FAIL b2b_second got %h at %0d expected 00000042 at %0d", got[1], at[1], 2*WIDTH + 2);
            end
        end
        checks++;
        if (busy34 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_restart got busy=%b expected 1", busy34);
        end
    endtask

    task automatic test_auto();
        logic [31:0] steps[4] = '{32'd0, 32'd5, 32'd5, 32'd17};
        int expect_dones[4] = '{0, 1, 0, 1};
        int total = 0;
        reset_n = 1'b0;
        bus.value_in = 32'd0;
        bus.auto_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            int dones = 0;
            logic [31:0] last = '0;
            bus.value_in = steps[p];
            for (int c = 0; c < 45; c++) begin
                @(negedge clk);
                if (bus.done) begin
                    dones++;
                    last = bus.digits_out;
                end
            end
            total += dones;
            checks++;
            if (dones != expect_dones[p] || (dones == 1 && last !== model_digits(steps[p]))) begin
                errors++;
                $display("[TB] FAIL auto_step%0d got %0d pulses digits=%h expected %0d pulses digits=%h",
                         p, dones, last, expect_dones[p], model_digits(steps[p]));
            end
        end
        checks++;
        if (total != 2) begin
            errors++;
            $display("[TB] FAIL auto_total got %0d expected 2", total);
        end
        bus.auto_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        bus.value_in = 32'd12345678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        bus.value_in = $urandom;
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) bus.start = 1'b1;
            if (c == 6) bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.digits_out !== 32'h0 ||
            bus.blank_mask !== 8'hFE || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear got %b %b %h %h %b expected 0 0 00000000 fe 0",
                     bus.busy, bus.done, bus.digits_out, bus.blank_mask, bus.overflow);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL midreset_idle got %0d active cycles expected 0", dones);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.value_in = '0;
        bus.start = 1'b0;
        bus.auto_en = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_normal();
        test_boundary();
        test_random();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_digit_sequencer.md
# bcd_digit_sequencer

Sequential binary-to-BCD converter and conversion scheduler for the calculator display path. It replaces the combinational divide/modulo chain that turns the displayed 32-bit operand into eight decimal digits for the display rotator. It accepts conversion requests from an explicit start pulse or automatically when the operand changes, and runs a double-dabble (shift-add-3) iteration once per clock. It presents registered digits, a leading-zero blank mask and an overflow flag.

## Interface
- `WIDTH`, default 32: binary input width; also the iteration count.
- `DIGITS`, default 8: number of BCD digits produced.
- `clk` input 1: 100 MHz system clock; all state on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `value_in` input WIDTH: unsigned operand to convert. The top level drives the operand currently selected for display.
- `start` input 1: conversion request, sampled each edge.
- `auto_en` input 1: when high, a change in `value_in` generates a request.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when the outputs update.
- `digits_out` output 4*DIGITS: packed BCD. Digit i occupies bits [4i+3:4i]; digit 0 is the least significant.
- `blank_mask` output DIGITS: bit i high means digit i is a leading zero and should be blanked.
- `overflow` output 1: the last converted value was ≥ 10^DIGITS.

## Operation
- States:
  - IDLE: waiting for a request.
  - CONVERT: WIDTH iterations.
- Request in IDLE = `start` OR `pending` OR (`auto_en` AND `value_in` != `last_value`).
- On the accepting edge:
  - shift register ← {DIGITS×4'b0, `value_in`}.
  - `last_value` ← `value_in`; iteration counter ← 0.
  - overflow-sticky ← 0; `pending` ← 0; next state CONVERT.
- Each CONVERT edge performs one iteration:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift the whole 4*DIGITS+WIDTH register left by 1.
  - The bit shifted out of the top nibble ORs into overflow-sticky.
  - Counter increments.
- On the edge where counter == WIDTH-1:
  - `digits_out` ← the BCD nibbles after that final iteration.
  - `overflow` ← the sticky value including the final shift-out.
  - `blank_mask` updates; `done` ← 1; next state IDLE.
- Arithmetic rules:
  - The truncated register yields `value_in` mod 10^DIGITS, so the digits equal ⌊v/10^i⌋ mod 10.
  - `overflow` is set exactly when v ≥ 10^DIGITS.
- `blank_mask[i]` = 1 iff digit i and every higher digit are zero, for i ≥ 1. `blank_mask[0]` is always 0, so the value 0 displays as "0".
- `start`, or an auto-request, arriving while CONVERT sets `pending`. It is serviced on the first IDLE edge and samples `value_in` at that edge. Multiple requests during one conversion collapse into one.
- `value_in` changes during CONVERT do not affect the running conversion. In auto mode the mismatch with `last_value` re-triggers the conversion once IDLE is reached.
- Counter width is clog2(WIDTH).

## Timing
- Reset (asynchronous assert; deassertion synchronised by the top level) sets:
  - state IDLE; `busy` 0; `done` 0; `pending` 0.
  - `digits_out` 0; `blank_mask` {DIGITS-1 ones, 0}, i.e. 8'hFE; `overflow` 0; `last_value` 0.
  - A value of 0 with `auto_en` high does not trigger a conversion after reset.
- Latency, with the request sampled on edge E0:
  - Iterations run on E1..E_WIDTH.
  - `digits_out`, `blank_mask` and `overflow` are valid and `done` is high after E_WIDTH: 32 edges for the defaults.
  - `done` falls on the next edge.
- `busy` is high from after E0 until E_WIDTH; it is 0 in the cycle `done` is high.
- Back-to-back: the earliest next accept is edge E_WIDTH+1, giving a period of WIDTH+1 cycles. The outputs hold their previous values throughout a conversion, so the display never shows partial results.
- A request on the same edge as completion is latched into `pending` and accepted at E_WIDTH+1.
- Reset mid-conversion aborts immediately; the outputs return to their reset values and no `done` pulse is issued.

## Test plan
- Normal conversion: `value_in`=12345678, `start` pulse → `done` 32 edges later; `digits_out`=32'h12345678, `blank_mask`=8'h00, `overflow`=0; `busy` high for 32 cycles.
- Small value with leading zeros: `value_in`=907, `start` → `digits_out`=32'h00000907, `blank_mask`=8'hF8, `overflow`=0. Then `value_in`=0, `start` → `blank_mask`=8'hFE.
- Overflow boundary:
  - 99999999 → 32'h99999999, `overflow`=0.
  - 100000000 → 32'h00000000, `overflow`=1.
  - 4294967295 → 32'h94967295, `overflow`=1.
- Busy collision: `start` at cycle 5 of a conversion with `value_in` then changed to 42 → exactly one extra conversion begins at E33; its result is 32'h00000042.
- Auto mode: `auto_en`=1, `value_in` steps 0→5→5→17 with gaps of at least 40 cycles → exactly two `done` pulses, producing 5 then 17. After reset with `value_in`=0, no conversion occurs.
- Reset mid-operation: assert `reset_n`=0 at iteration 10 → `busy`, `done`, `digits_out` and `pending` clear immediately. After release, no `done` occurs until a new request.
